eic_multi_channel: RTL

Parametrised external interrupt controller, the N-channel successor of the single-source EIC that drives the core's EIC_I_Req / EIC_I_Id inputs. It does the following:
- Synchronises NUM_CH asynchronous interrupt lines and latches them as edge- or level-sensitive pending bits.
- Applies a software mask and selects a winner by priority.
- Presents a held request/ID to the Branch Exception Unit, then tracks in-service state until software writes EOI.
- Is programmed through the core's IO read/write port, with one-cycle registered read data.

---
 rtl/eic_multi_channel.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/eic_multi_channel.sv
// N-channel external interrupt controller: input synchronisers, edge/level pending bits,
// masked priority arbitration and a request/service handshake. Optional macro: EIC_ROUND_ROBIN_EN.
module eic_multi_channel #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned ID_W        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned DATA_W     = 32
) (
  input  logic              Sys_Clock,
  input  logic              Sys_Reset,
  input  logic [NUM_CH-1:0] Irq_In,
  input  logic              IO_EnR,
  input  logic              IO_EnW,
  input  logic [1:0]        IO_Addr,
  input  logic [DATA_W-1:0] IO_DataW,
  output logic [DATA_W-1:0] IO_DataR,
  output logic              EIC_I_Req,
  output logic [ID_W-1:0]   EIC_I_Id,
  input  logic              EIC_I_Ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s, s_d, rise, pend, mask, mode, cand, pend_nxt, w1c, ack_clr;
  logic [ID_W-1:0]   win, insvc, insvc_nxt, id_nxt;
  logic              req_nxt, wr_pend, wr_mask, wr_mode, eoi;
  logic [DATA_W-1:0] rd_mux;

  // Input synchronisers plus one extra stage for edge detection
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= Irq_In;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign wr_pend = IO_EnW && (IO_Addr == 2'd0);
  assign wr_mask = IO_EnW && (IO_Addr == 2'd1);
  assign wr_mode = IO_EnW && (IO_Addr == 2'd2);
  assign eoi     = IO_EnW && (IO_Addr == 2'd3);
  assign w1c     = wr_pend ? IO_DataW[NUM_CH-1:0] : '0;
  assign cand    = pend & mask;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(NUM_CH); i++)
      ack_clr[i] = (state == REQ) && EIC_I_Ack && (EIC_I_Id == ID_W'(i));
  end

  // Edge channels: set beats clear; level channels follow the synchronised line
  assign pend_nxt = (mode & (rise | (pend & ~(w1c | ack_clr)))) | (~mode & s);

`ifdef EIC_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr, win_hi, win_lo;
  logic            hi_any;

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset)                         ptr <= ID_W'(NUM_CH - 1);
    else if ((state == REQ) && EIC_I_Ack)  ptr <= EIC_I_Id;
  end

  // First candidate above the pointer, else wrap to the lowest candidate
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hi_any = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (cand[i]) win_lo = ID_W'(i);
      if (cand[i] && (ID_W'(i) > ptr)) begin
        win_hi = ID_W'(i);
        hi_any = 1'b1;
      end
    end
    win = hi_any ? win_hi : win_lo;
  end
`else
  always_comb begin
    win = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--)
      if (cand[i]) win = ID_W'(i);
  end
`endif

  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    id_nxt    = EIC_I_Id;
    insvc_nxt = insvc;
    case (state)
      IDLE: if (|cand) begin
        state_nxt = REQ;
        req_nxt   = 1'b1;
        id_nxt    = win;
      end
      REQ: if (EIC_I_Ack) begin
        state_nxt = SVC;
        insvc_nxt = EIC_I_Id;
      end else begin
        req_nxt = 1'b1;
      end
      SVC: if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (IO_Addr)
      2'd0: rd_mux[NUM_CH-1:0] = pend;
      2'd1: rd_mux[NUM_CH-1:0] = mask;
      2'd2: rd_mux[NUM_CH-1:0] = mode;
      default: begin
        rd_mux[DATA_W-1]   = (state == SVC);
        rd_mux[DATA_W-2]   = (state == REQ);
        rd_mux[ID_W-1:0]   = insvc;
      end
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      state     <= IDLE;
      EIC_I_Req <= 1'b0;
      EIC_I_Id  <= '0;
      insvc     <= '0;
      pend      <= '0;
      mask      <= '0;
      mode      <= '0;
      IO_DataR  <= '0;
    end else begin
      state     <= state_nxt;
      EIC_I_Req <= req_nxt;
      EIC_I_Id  <= id_nxt;
      insvc     <= insvc_nxt;
      pend      <= pend_nxt;
      if (wr_mask) mask <= IO_DataW[NUM_CH-1:0];
      if (wr_mode) mode <= IO_DataW[NUM_CH-1:0];
      if (IO_EnR)  IO_DataR <= rd_mux;
    end
  end

  // Write-data bits above the channel count carry no meaning
  if (NUM_CH < DATA_W) begin : g_unused
    logic unused_dataw;
    assign unused_dataw = ^IO_DataW[DATA_W-1:NUM_CH];
  end

endmodule
